// File: rtl/pipelined_add_sub_pkg.sv
// Shared constants and helpers for the pipelined adder/subtractor.
package pipelined_add_sub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_STAGES = 4;

    // Largest positive two's-complement value of a w-bit word (w <= 64).
    function automatic logic [63:0] sat_max(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Most negative two's-complement value of a w-bit word (w <= 64).
    function automatic logic [63:0] sat_min(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/pipelined_add_sub_fa.sv
// One-bit gate-level full adder, chained per slice by pipelined_add_sub.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic p;

    assign p    = a ^ b;
    assign sum  = p ^ cin;
    assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/pipelined_add_sub.sv
// Pipelined WIDTH-bit adder/subtractor: STAGES ripple slices, carry registered
// between slices, operands skewed so one op is accepted per cycle.
// Optional feature: define ADDER_SAT_EN to clamp the result on signed overflow.
module pipelined_add_sub
    import pipelined_add_sub_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             zero
);

    localparam int SW = WIDTH / STAGES;

    if ((STAGES < 1) || (WIDTH % STAGES != 0)) begin : g_param_chk
        $error("pipelined_add_sub: WIDTH must be a multiple of STAGES");
    end

    // Index 0 is the unregistered input side; index k+1 is the output register of slice k.
    logic [STAGES:0]                  vld_pipe;
    logic [STAGES:0][WIDTH-1:0]       res;
    logic [STAGES:0]                  cy;
    logic [STAGES-1:0][WIDTH-1:0]     op_a;
    logic [STAGES-1:0][WIDTH-1:0]     op_b;
    logic                             cmsb_q;
    logic                             adv;
    logic [WIDTH-1:0]                 raw_sum;

    // A full pipe only moves when the consumer takes the head; otherwise everything freezes.
    assign adv      = out_ready | ~vld_pipe[STAGES];
    assign in_ready = adv;

    // Subtraction is A + ~B + 1; c_in only matters for addition.
    assign vld_pipe[0] = in_valid;
    assign op_a[0]     = a;
    assign op_b[0]     = (sub == OP_SUB) ? ~b : b;
    assign res[0]      = '0;
    assign cy[0]       = (sub == OP_SUB) ? 1'b1 : c_in;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [SW:0]      c;
        logic [SW-1:0]    s;
        logic             v_q;
        logic [WIDTH-1:0] r_q;
        logic             cy_q;

        assign c[0] = cy[k];

        for (genvar j = 0; j < SW; j++) begin : g_bit
            full_adder_cell u_fa (
                .a   (op_a[k][k*SW + j]),
                .b   (op_b[k][k*SW + j]),
                .cin (c[j]),
                .sum (s[j]),
                .cout(c[j+1])
            );
        end

        // Slice result register: lower bits carried along, this slice's bits inserted.
        always_ff @(posedge clk) begin
            if (rst) begin
                v_q  <= 1'b0;
                r_q  <= '0;
                cy_q <= 1'b0;
            end else if (adv) begin
                v_q             <= vld_pipe[k];
                r_q             <= res[k];
                r_q[k*SW +: SW] <= s;
                cy_q            <= c[SW];
            end
        end

        assign vld_pipe[k+1] = v_q;
        assign res[k+1]      = r_q;
        assign cy[k+1]       = cy_q;

        if (k < STAGES - 1) begin : g_skew
            logic [WIDTH-1:0] a_q;
            logic [WIDTH-1:0] b_q;

            // Operand delay line feeding the higher slices.
            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= op_a[k];
                    b_q <= op_b[k];
                end
            end

            assign op_a[k+1] = a_q;
            assign op_b[k+1] = b_q;
        end else begin : g_last
            // Carry into the MSB, kept for signed-overflow detection.
            always_ff @(posedge clk) begin
                if (rst) begin
                    cmsb_q <= 1'b0;
                end else if (adv) begin
                    cmsb_q <= c[SW-1];
                end
            end
        end
    end

    assign raw_sum   = res[STAGES];
    assign out_valid = vld_pipe[STAGES];
    assign c_out     = cy[STAGES];
    assign ovf       = cy[STAGES] ^ cmsb_q;

`ifdef ADDER_SAT_EN
    localparam logic [WIDTH-1:0] SAT_HI = WIDTH'(sat_max(WIDTH));
    localparam logic [WIDTH-1:0] SAT_LO = WIDTH'(sat_min(WIDTH));

    // Clamp on overflow: a wrapped negative result means positive overflow and vice versa.
    always_comb begin
        sum = raw_sum;
        if (ovf) begin
            sum = raw_sum[WIDTH-1] ? SAT_HI : SAT_LO;
        end
    end
`else
    assign sum = raw_sum;
`endif

    // Qualified by valid so an empty pipe reports zero=0.
    assign zero = out_valid & (sum == '0);

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Self-checking bench for pipelined_add_sub (WIDTH=16, STAGES=4).
module tb_pipelined_add_sub;

    localparam int W = 16;
    localparam int S = 4;

    typedef logic [W+2:0] res_t;   // {sum, c_out, ovf, zero}

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         c_out;
    logic         ovf;
    logic         zero;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    res_t exp_q[$];
    res_t got_q[$];
    int   got_cyc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    pipelined_add_sub #(.WIDTH(W), .STAGES(S)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .c_in     (c_in),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .c_out    (c_out),
        .ovf      (ovf),
        .zero     (zero)
    );

    // Reference: plain integer arithmetic on the operands.
    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic ci, input logic sb);
        int unsigned ux = x;
        int unsigned uy = y;
        int unsigned t;
        int          sx = int'($signed(x));
        int          sy = int'($signed(y));
        int          exact;
        logic        co;
        logic        ov;
        logic [W-1:0] s;
        if (sb) begin
            t     = ux - uy;
            co    = (ux >= uy);
            exact = sx - sy;
        end else begin
            t     = ux + uy + int'(ci);
            co    = (t >= 32'd65536);
            exact = sx + sy + int'(ci);
        end
        s  = t[W-1:0];
        ov = (exact > 32767) || (exact < -32768);
`ifdef ADDER_SAT_EN
        if (ov) s = (exact > 0) ? 16'h7FFF : 16'h8000;
`endif
        return {s, co, ov, (s == '0)};
    endfunction

    // One clock: log accepted ops into the model queue and retired results.
    task automatic tick();
        #1;
        if (in_valid && in_ready && !rst) exp_q.push_back(model(a, b, c_in, sub));
        if (out_valid && out_ready && !rst) begin
            got_q.push_back({sum, c_out, ovf, zero});
            got_cyc.push_back(cyc);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rand_op();
        logic [W-1:0] edges [5] = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0001};
        a    = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 4)] : W'($urandom);
        b    = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 4)] : W'($urandom);
        c_in = 1'($urandom);
        sub  = 1'($urandom);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 60 && got_q.size() < exp_q.size(); i++) tick();
    endtask

    task automatic clear_q();
        exp_q.delete();
        got_q.delete();
        got_cyc.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks += 6;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
        if (sum !== '0)         begin errors++; $display("FAIL reset_sum: got %h exp 0000", sum); end
        if (c_out !== 1'b0)     begin errors++; $display("FAIL reset_c_out: got %b exp 0", c_out); end
        if (ovf !== 1'b0)       begin errors++; $display("FAIL reset_ovf: got %b exp 0", ovf); end
        if (zero !== 1'b0)      begin errors++; $display("FAIL reset_zero: got %b exp 0", zero); end
        if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready: got %b exp 1", in_ready); end
        clear_q();
    endtask

    task automatic test_directed();
        logic [W-1:0] va [7] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000, 16'h0005, 16'h0000};
        logic [W-1:0] vb [7] = '{16'h0001, 16'h0001, 16'h0001, 16'h0007, 16'h0001, 16'h0005, 16'h0000};
        logic         vc [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic         vs [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
`ifdef ADDER_SAT_EN
        res_t ve [7] = '{{16'h1235, 3'b000}, {16'h0000, 3'b101}, {16'h7FFF, 3'b010},
                         {16'hFFFE, 3'b000}, {16'h8000, 3'b110}, {16'h0000, 3'b101},
                         {16'h0001, 3'b000}};
`else
        res_t ve [7] = '{{16'h1235, 3'b000}, {16'h0000, 3'b101}, {16'h8000, 3'b010},
                         {16'hFFFE, 3'b000}, {16'h7FFF, 3'b110}, {16'h0000, 3'b101},
                         {16'h0001, 3'b000}};
`endif
        int n;
        for (int i = 0; i < 7; i++) begin
            out_ready = 1'b1;
            in_valid = 1'b1; a = va[i]; b = vb[i]; c_in = vc[i]; sub = vs[i];
            tick();
            in_valid = 1'b0;
            n = 1;
            while (!out_valid && n < 20) begin tick(); n++; end
            checks += 2;
            if (n != S) begin errors++; $display("FAIL directed_latency[%0d]: got %0d exp %0d", i, n, S); end
            if ({sum, c_out, ovf, zero} !== ve[i]) begin
                errors++;
                $display("FAIL directed_result[%0d]: got %h exp %h", i, {sum, c_out, ovf, zero}, ve[i]);
            end
            tick();
        end
        clear_q();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            rand_op();
            tick();
        end
        drain();
        checks++;
        if (got_q.size() != 8 || exp_q.size() != 8) begin
            errors++;
            $display("FAIL b2b_count: got %0d exp 8 (accepted %0d)", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks += 2;
            if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL b2b_result[%0d]: got %h exp %h", i, got_q[i], exp_q[i]);
            end
            if (got_cyc[i] - got_cyc[0] != i) begin
                errors++; $display("FAIL b2b_spacing[%0d]: got %0d exp %0d", i, got_cyc[i] - got_cyc[0], i);
            end
        end
        clear_q();
    endtask

    task automatic test_backpressure();
        logic [W+2:0] hold;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin in_valid = 1'b1; rand_op(); tick(); end
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; rand_op();
            #1;
            hold = {sum, c_out, ovf, zero};
            checks++;
            if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready[%0d]: got %b exp 0", i, in_ready); end
            tick();
            checks += 2;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_out_valid[%0d]: got %b exp 1", i, out_valid); end
            if ({sum, c_out, ovf, zero} !== hold) begin
                errors++; $display("FAIL stall_hold[%0d]: got %h exp %h", i, {sum, c_out, ovf, zero}, hold);
            end
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin in_valid = 1'b1; rand_op(); tick(); end
        drain();
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL stall_count: got %0d exp %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL stall_result[%0d]: got %h exp %h", i, got_q[i], exp_q[i]);
            end
        end
        clear_q();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            rand_op();
            tick();
        end
        drain();
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL random_count: got %0d exp %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL random_result[%0d]: got %h exp %h", i, got_q[i], exp_q[i]);
            end
        end
        clear_q();
    endtask

    task automatic test_reset_mid();
        int   n;
        int   seen;
        res_t e;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin in_valid = 1'b1; rand_op(); tick(); end
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks += 2;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b exp 0", out_valid); end
        // Only the first op had time to retire before the flush.
        if (got_q.size() != 1) begin
            errors++; $display("FAIL midrst_retired: got %0d exp 1", got_q.size());
        end else begin
            checks++;
            if (got_q[0] !== exp_q[0]) begin
                errors++; $display("FAIL midrst_first: got %h exp %h", got_q[0], exp_q[0]);
            end
        end
        clear_q();
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) seen++;
            tick();
        end
        checks++;
        if (seen != 0 || got_q.size() != 0) begin
            errors++; $display("FAIL midrst_stale: got %0d valid cycles exp 0", seen);
        end
        in_valid = 1'b1; rand_op();
        e = model(a, b, c_in, sub);
        tick();
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin tick(); n++; end
        checks += 2;
        if (n != S) begin errors++; $display("FAIL midrst_latency: got %0d exp %0d", n, S); end
        if ({sum, c_out, ovf, zero} !== e) begin
            errors++; $display("FAIL midrst_result: got %h exp %h", {sum, c_out, ovf, zero}, e);
        end
        tick();
        clear_q();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

endmodule
